// File: rtl/gray_monitor.sv
// Gray-code step monitor: decodes sampled Gray values, checks single-step progress,
// counts wraps and flags illegal jumps. Optional error counter: GRAY_MON_ERRCNT_EN.
module gray_monitor #(
  parameter int W      = 3,
  parameter int WRAP_W = 4
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_valid,
  input  logic [W-1:0]      i_gray,
  input  logic              i_clear,
  output logic [W-1:0]      o_bin,
  output logic              o_bin_valid,
  output logic              o_wrap,
  output logic [WRAP_W-1:0] o_wraps,
  output logic              o_err
`ifdef GRAY_MON_ERRCNT_EN
  ,
  output logic [7:0]        o_err_cnt
`endif
);

  localparam logic [1:0] S_EMPTY = 2'd0;
  localparam logic [1:0] S_TRACK = 2'd1;
  localparam logic [1:0] S_FAULT = 2'd2;

  logic [1:0]        r_state;
  logic [W-1:0]      r_prev;
  logic [W-1:0]      r_bin;
  logic              r_bin_valid;
  logic              r_wrap;
  logic [WRAP_W-1:0] r_wraps;
  logic              r_err;

  logic [W-1:0]      w_bin;
  logic [W-1:0]      w_step;
  logic              w_is_hold;
  logic              w_is_inc;
  logic              w_prev_max;
  logic              w_wraps_sat;

  logic [1:0]        w_state_next;
  logic [W-1:0]      w_prev_next;
  logic [W-1:0]      w_bin_next;
  logic              w_bin_valid_next;
  logic              w_wrap_next;
  logic [WRAP_W-1:0] w_wraps_next;
  logic              w_err_next;

  // Each binary bit is the XOR of all Gray bits at or above it.
  genvar gi;
  generate
    for (gi = 0; gi < W; gi++) begin : g_dec
      assign w_bin[gi] = ^i_gray[W-1:gi];
    end
  endgenerate

  assign w_step      = w_bin - r_prev;
  assign w_is_hold   = (w_step == '0);
  assign w_is_inc    = (w_step == W'(1));
  assign w_prev_max  = &r_prev;
  assign w_wraps_sat = &r_wraps;

  always_comb begin
    w_state_next     = r_state;
    w_prev_next      = r_prev;
    w_bin_next       = r_bin;
    w_bin_valid_next = 1'b0;
    w_wrap_next      = 1'b0;
    w_wraps_next     = r_wraps;
    w_err_next       = r_err;

    // Clear wins over a same-cycle sample; Bin keeps its last value.
    if (i_clear) begin
      w_state_next = S_EMPTY;
      w_prev_next  = '0;
      w_wraps_next = '0;
      w_err_next   = 1'b0;
    end else begin
      case (r_state)
        S_EMPTY: begin
          if (i_valid) begin
            w_prev_next      = w_bin;
            w_bin_next       = w_bin;
            w_bin_valid_next = 1'b1;
            w_state_next     = S_TRACK;
          end
        end
        S_TRACK: begin
          if (i_valid) begin
            w_bin_next       = w_bin;
            w_bin_valid_next = 1'b1;
            if (w_is_inc) begin
              w_prev_next = w_bin;
              if (w_prev_max) begin
                w_wrap_next = 1'b1;
                if (!w_wraps_sat) begin
                  w_wraps_next = r_wraps + WRAP_W'(1);
                end
              end
            end else if (!w_is_hold) begin
              w_prev_next  = w_bin;
              w_err_next   = 1'b1;
              w_state_next = S_FAULT;
            end
          end
        end
        S_FAULT: begin
          if (i_valid) begin
            w_prev_next      = w_bin;
            w_bin_next       = w_bin;
            w_bin_valid_next = 1'b1;
          end
        end
        default: begin
          w_state_next = S_EMPTY;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= S_EMPTY;
      r_prev      <= '0;
      r_bin       <= '0;
      r_bin_valid <= 1'b0;
      r_wrap      <= 1'b0;
      r_wraps     <= '0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_prev      <= w_prev_next;
      r_bin       <= w_bin_next;
      r_bin_valid <= w_bin_valid_next;
      r_wrap      <= w_wrap_next;
      r_wraps     <= w_wraps_next;
      r_err       <= w_err_next;
    end
  end

  assign o_bin       = r_bin;
  assign o_bin_valid = r_bin_valid;
  assign o_wrap      = r_wrap;
  assign o_wraps     = r_wraps;
  assign o_err       = r_err;

`ifdef GRAY_MON_ERRCNT_EN
  logic [7:0] r_err_cnt;
  logic [7:0] w_err_cnt_next;
  logic       w_count_en;

  // In FAULT the step check keeps running, but only to feed this counter.
  assign w_count_en = i_valid && !w_is_hold && !w_is_inc &&
                      ((r_state == S_TRACK) || (r_state == S_FAULT));

  always_comb begin
    w_err_cnt_next = r_err_cnt;
    if (i_clear) begin
      w_err_cnt_next = 8'd0;
    end else if (w_count_en && (r_err_cnt != 8'hFF)) begin
      w_err_cnt_next = r_err_cnt + 8'd1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_err_cnt <= 8'd0;
    end else begin
      r_err_cnt <= w_err_cnt_next;
    end
  end

  assign o_err_cnt = r_err_cnt;
`endif

endmodule

// File: tb/tb_gray_monitor.sv
// Scoreboard bench for gray_monitor: stimulus pushes expected Bin/Wrap, a negedge
// monitor pops on every Bin_valid; register-like outputs are checked inline.
module tb_gray_monitor;

  localparam int W      = 3;
  localparam int WRAP_W = 2;

  typedef struct packed {
    logic [W-1:0] bin;
    logic         wrap;
  } exp_t;

  logic              clk;
  logic              rst_n;
  logic              valid;
  logic [W-1:0]      gray;
  logic              clear;
  logic [W-1:0]      bin;
  logic              bin_valid;
  logic              wrap;
  logic [WRAP_W-1:0] wraps;
  logic              err;
`ifdef GRAY_MON_ERRCNT_EN
  logic [7:0]        err_cnt;
`endif

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fails  = 0;

  logic [W-1:0] gseq [8] = '{3'b001, 3'b011, 3'b010, 3'b110,
                             3'b111, 3'b101, 3'b100, 3'b000};

  gray_monitor #(.W(W), .WRAP_W(WRAP_W)) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_valid    (valid),
    .i_gray     (gray),
    .i_clear    (clear),
    .o_bin      (bin),
    .o_bin_valid(bin_valid),
    .o_wrap     (wrap),
    .o_wraps    (wraps),
    .o_err      (err)
`ifdef GRAY_MON_ERRCNT_EN
    ,
    .o_err_cnt  (err_cnt)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int act, input int expv);
    n_checks++;
    if (act !== expv) begin
      n_fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end else begin
      $display("ok   %s: %0d", name, act);
    end
  endtask

  // Monitor: every Bin_valid pulse must match the oldest expected sample.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bin_valid) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fails++;
          $display("FAIL unexpected_bin_valid: got bin=%0d wrap=%0d with empty queue", bin, wrap);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          if (bin !== e.bin || wrap !== e.wrap) begin
            n_fails++;
            $display("FAIL sample: got bin=%0d wrap=%0d expected bin=%0d wrap=%0d",
                     bin, wrap, e.bin, e.wrap);
          end else begin
            $display("ok   sample: bin=%0d wrap=%0d", bin, wrap);
          end
        end
      end else begin
        n_checks++;
        if (wrap !== 1'b0) begin
          n_fails++;
          $display("FAIL stray_wrap: got wrap=%0d expected 0 without bin_valid", wrap);
        end
      end
    end
  end

  // Called at posedge+1; applies inputs for exactly one capturing edge.
  task automatic drive(input logic v, input logic [W-1:0] g, input logic c);
    valid = v;
    gray  = g;
    clear = c;
    @(posedge clk);
    #1;
    valid = 1'b0;
    clear = 1'b0;
  endtask

  task automatic samp(input logic [W-1:0] g, input logic [W-1:0] eb, input logic ew);
    exp_t e;
    e.bin  = eb;
    e.wrap = ew;
    exp_q.push_back(e);
    drive(1'b1, g, 1'b0);
  endtask

  task automatic gap();
    drive(1'b0, '0, 1'b0);
  endtask

  initial begin
    rst_n = 1'b1;
    valid = 1'b0;
    gray  = '0;
    clear = 1'b0;
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_bin", int'(bin), 0);
    check("reset_bin_valid", int'(bin_valid), 0);
    check("reset_wrap", int'(wrap), 0);
    check("reset_wraps", int'(wraps), 0);
    check("reset_err", int'(err), 0);
    rst_n = 1'b1;
    gap();

    // Full cycle: reference 000 then seven steps and a wrap back to 0.
    samp(3'b000, 3'd0, 1'b0);
    for (int k = 0; k < 8; k++) samp(gseq[k], W'((k + 1) % 8), (k == 7));
    check("cycle_wraps", int'(wraps), 1);
    check("cycle_err", int'(err), 0);

    // Illegal jump 1->3, then legal steps through 0: no wrap, Wraps frozen.
    samp(3'b001, 3'd1, 1'b0);
    samp(3'b010, 3'd3, 1'b0);
    check("jump_err", int'(err), 1);
    check("jump_bin", int'(bin), 3);
    for (int k = 2; k < 8; k++) samp(gseq[k], W'((k + 1) % 8), 1'b0);
    check("fault_wraps_frozen", int'(wraps), 1);
    check("fault_err_sticky", int'(err), 1);
    drive(1'b0, '0, 1'b1);
    check("clear_err", int'(err), 0);
    check("clear_wraps", int'(wraps), 0);
    samp(3'b000, 3'd0, 1'b0);
    samp(3'b001, 3'd1, 1'b0);
    check("post_clear_err", int'(err), 0);

    // Hold with gaps: 011 three times.
    samp(3'b011, 3'd2, 1'b0);
    gap();
    gap();
    samp(3'b011, 3'd2, 1'b0);
    gap();
    samp(3'b011, 3'd2, 1'b0);
    check("hold_err", int'(err), 0);
    check("hold_wraps", int'(wraps), 0);

    // Clear/Valid collision: sample discarded, Bin held, back to EMPTY.
    drive(1'b1, 3'b111, 1'b1);
    check("collide_bin_valid", int'(bin_valid), 0);
    check("collide_bin", int'(bin), 2);
    samp(3'b110, 3'd4, 1'b0);
    check("collide_empty_ref_err", int'(err), 0);

    // Saturation: one wrap plus four full cycles on a 2-bit counter.
    samp(3'b111, 3'd5, 1'b0);
    samp(3'b101, 3'd6, 1'b0);
    samp(3'b100, 3'd7, 1'b0);
    samp(3'b000, 3'd0, 1'b1);
    check("sat_wraps_1", int'(wraps), 1);
    for (int c = 0; c < 4; c++) begin
      for (int k = 0; k < 8; k++) samp(gseq[k], W'((k + 1) % 8), (k == 7));
      check("sat_wraps", int'(wraps), (c + 2 > 3) ? 3 : c + 2);
    end

    // Asynchronous reset pulse inside a clock period.
    samp(3'b001, 3'd1, 1'b0);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("midrst_bin", int'(bin), 0);
    check("midrst_wraps", int'(wraps), 0);
    check("midrst_err", int'(err), 0);
    check("midrst_bin_valid", int'(bin_valid), 0);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    samp(3'b101, 3'd6, 1'b0);
    check("after_rst_ref_err", int'(err), 0);
    samp(3'b100, 3'd7, 1'b0);
    samp(3'b001, 3'd1, 1'b0);
    check("after_rst_jump_err", int'(err), 1);
`ifdef GRAY_MON_ERRCNT_EN
    check("errcnt_one", int'(err_cnt), 1);
    drive(1'b0, '0, 1'b1);
    check("errcnt_clear", int'(err_cnt), 0);
    samp(3'b001, 3'd1, 1'b0);
    samp(3'b010, 3'd3, 1'b0);
    samp(3'b101, 3'd6, 1'b0);
    samp(3'b011, 3'd2, 1'b0);
    check("errcnt_three", int'(err_cnt), 3);
    check("errcnt_err", int'(err), 1);
`endif

    repeat (3) @(posedge clk);
    #1;
    check("queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/gray_monitor.md
Name: gray_monitor

Overview:
Downstream consumer of the 3-bit Gray counter output.
- Samples the Gray code on a strobe and decodes it to binary.
- Checks that every new sample is a legal single step (hold or +1 mod 2^W).
- Counts wrap-arounds and flags illegal transitions with a sticky error.
- Sits between the Gray counter and the display/debug logic in the same clock domain.

Parameters:
- W, 3, Gray/binary width.
- WRAP_W, 4, width of the wrap counter (saturating).

Ports:
- Clk  input  1  system clock, rising edge.
- Reset  input  1  asynchronous, active-low reset.
- Valid  input  1  sample strobe; Gray_in is captured on a rising Clk edge with Valid=1.
- Gray_in  input  W  Gray code from the upstream counter.
- Clear  input  1  synchronous clear of tracking state, counters and error.
- Bin  output  W  registered binary decode of the last accepted sample.
- Bin_valid  output  1  one-cycle pulse: Bin updated this cycle.
- Wrap  output  1  one-cycle pulse: legal step from 2^W-1 to 0 accepted.
- Wraps  output  WRAP_W  number of wraps since reset/Clear; saturates at all-ones.
- Err  output  1  sticky illegal-transition flag.

Behaviour:
- Reset low (async): state=EMPTY; Bin=0, Bin_valid=0, Wrap=0, Wraps=0, Err=0; prev sample=0.
- Decode: b[W-1]=g[W-1]; b[i]=b[i+1]^g[i]. Combinational decode, registered into Bin.
- Latency: Bin, Bin_valid and Wrap appear 1 cycle after the capturing edge. Bin_valid and Wrap are low whenever Valid was low.
- State EMPTY (no reference sample):
  - On Valid: store the decoded value as prev, update Bin, pulse Bin_valid, go to TRACK.
  - No step check in this state.
- State TRACK: on Valid, compute d=(new-prev) mod 2^W.
  - d==0: hold. Update Bin, pulse Bin_valid, no count.
  - d==1: legal step. Update Bin and prev, pulse Bin_valid. If prev==2^W-1 and new==0: pulse Wrap and increment Wraps, which saturates and never rolls over.
  - Any other d: Err<=1, update Bin and prev, pulse Bin_valid, go to FAULT. No Wrap pulse and no Wraps change.
- State FAULT:
  - On Valid: Bin, prev and Bin_valid update as usual.
  - No step checking, Wrap never pulses, Wraps frozen, Err stays 1.
- Clear (any state): next state=EMPTY, Wraps=0, Err=0, Bin_valid=0, Wrap=0; Bin holds its value.
- Priority:
  - Clear has priority over Valid in the same cycle; that sample is discarded.
  - Reset has priority over everything.
- Reset asserted mid-sequence: all outputs return to reset values immediately. The first Valid after release is treated as the EMPTY reference.
- Wrap detection uses only the binary decode, never an upstream overflow flag.
- Exactly one FSM (EMPTY/TRACK/FAULT); encoding is free. No illegal-state lockup: any unused encoding goes to EMPTY.

Optional Feature:
- Macro GRAY_MON_ERRCNT_EN.
- When defined:
  - Adds output Err_cnt [7:0]: count of illegal transitions.
  - Counts in TRACK and also in FAULT, where the step check keeps running for counting only.
  - Saturates at 255; cleared by Reset and Clear.
  - Err behaviour is unchanged.
- When undefined: the port and its logic are absent, and FAULT performs no checks.

Test Plan:
- Full cycle, W=3. Valid every cycle with Gray 000,001,011,010,110,111,101,100,000 -> Bin 0,1,2,3,4,5,6,7,0 one cycle later; single Wrap pulse on the last sample; Wraps=1; Err=0.
- Hold and gaps. Gray 011 sampled three times with Valid low gaps in between -> Bin=2 each time, Bin_valid pulses 3 times, Wraps unchanged, Err=0.
- Illegal jump. Sequence 001 then 010 (bin 1->3) -> Err=1, Bin=3. Further legal 110,111,101,100,000 -> no Wrap, Wraps frozen. Clear -> Err=0, Wraps=0. Next Valid 000 is accepted as reference with no error.
- Clear/Valid collision. Clear=1 and Valid=1 with Gray 111 in the same cycle -> Bin_valid=0 next cycle, Bin unchanged, state EMPTY.
- Saturation and reset. WRAP_W=2, 5 full cycles -> Wraps=3. Reset low for a partial cycle mid-sequence -> all outputs 0 immediately; first Valid after release gives no Err regardless of value.
- With GRAY_MON_ERRCNT_EN: three illegal jumps (1->3, 3->6, 6->2) -> Err_cnt=3, Err=1.
